// File: rtl/calc1_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc1_port_driver
// Purpose  : Drives one host operation onto a two-beat calculator port
//            (command+operand1, then operand2), waits for the response with a
//            cycle timeout, and presents the result to the host until taken.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_port_driver #(
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [0:3]  op_cmd,
  input  logic [0:31] op_d1,
  input  logic [0:31] op_d2,
  output logic [0:3]  req_cmd,
  output logic [0:31] req_data,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic        err_stray
);

  // Counter value on the last WAIT edge before the operation is abandoned.
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [0:31] r_d2;
  logic        w_resp_seen;

  assign w_resp_seen = (out_resp != 2'b00);

  // Operation sequencer; every host- and bus-facing output is registered here
  // so it changes only on the edge that enters the corresponding state.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_d2        <= '0;
      op_ready    <= 1'b1;
      req_cmd     <= '0;
      req_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      // A response outside WAIT is never captured, only flagged (sticky).
      if (w_resp_seen && (r_state != S_WAIT)) begin
        err_stray <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            r_d2     <= op_d2;
            if (op_cmd != 4'd0) begin
              // First beat goes out in the cycle after acceptance.
              r_state  <= S_CMD;
              req_cmd  <= op_cmd;
              req_data <= op_d1;
            end else begin
              // NOP completes immediately without touching the bus.
              r_state     <= S_DONE;
              rsp_valid   <= 1'b1;
              rsp_resp    <= '0;
              rsp_data    <= '0;
              rsp_timeout <= 1'b0;
            end
          end
        end

        S_CMD: begin
          r_state  <= S_DATA;
          req_cmd  <= '0;
          req_data <= r_d2;
        end

        S_DATA: begin
          r_state  <= S_WAIT;
          req_data <= '0;
          r_cnt    <= 8'd0;
        end

        S_WAIT: begin
          if (w_resp_seen) begin
            r_state     <= S_DONE;
            rsp_valid   <= 1'b1;
            rsp_resp    <= out_resp;
            rsp_data    <= out_data;
            rsp_timeout <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == c_WAIT_LAST) begin
              r_state     <= S_DONE;
              rsp_valid   <= 1'b1;
              rsp_resp    <= '0;
              rsp_data    <= '0;
              rsp_timeout <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Result fields are left untouched so they stay stable while stalled.
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
            op_ready  <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          op_ready  <= 1'b1;
          rsp_valid <= 1'b0;
          req_cmd   <= '0;
          req_data  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc1_port_driver
// Purpose  : Self-checking bench for calc1_port_driver: directed scenarios
//            followed by randomized operations against an outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_port_driver;

  localparam int T = 4;

  logic        c_clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_d1;
  logic [0:31] op_d2;
  logic [0:3]  req_cmd;
  logic [0:31] req_data;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic        err_stray;

  int n_vec  = 0;
  int n_miss = 0;
  bit exp_stray = 1'b0;

  calc1_port_driver #(.TIMEOUT(T)) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_cmd     (op_cmd),
    .op_d1      (op_d1),
    .op_d2      (op_d2),
    .req_cmd    (req_cmd),
    .req_data   (req_data),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_resp   (rsp_resp),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .err_stray  (err_stray)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_op_ready"},  32'(op_ready), 32'd1);
    chk({tag, "_req_cmd"},   32'(req_cmd), 32'd0);
    chk({tag, "_req_data"},  req_data, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_resp"},  32'(rsp_resp), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data, 32'd0);
    chk({tag, "_rsp_to"},    32'(rsp_timeout), 32'd0);
    chk({tag, "_stray"},     32'(err_stray), 32'd0);
  endtask

  // Runs one operation. The response is offered on the n-th WAIT edge; if n
  // exceeds the timeout the operation must end by timeout instead.
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                       input int n, input logic [1:0] code, input logic [31:0] data,
                       input int stall, input bit stray_in_data);
    logic [1:0]  er;
    logic [31:0] ed;
    logic        et;
    int          edges;
    chk("accept_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_cmd = cmd; op_d1 = d1; op_d2 = d2;
    step();
    op_valid = 1'b0; op_cmd = 4'($urandom); op_d1 = $urandom; op_d2 = $urandom;
    if (cmd == 4'd0) begin
      er = 2'd0; ed = 32'd0; et = 1'b0;
      chk("nop_req_cmd", 32'(req_cmd), 32'd0);
      chk("nop_req_data", req_data, 32'd0);
    end else begin
      chk("cmd_req_cmd", 32'(req_cmd), 32'(cmd));
      chk("cmd_req_data", req_data, d1);
      chk("cmd_op_ready", 32'(op_ready), 32'd0);
      step();
      chk("data_req_cmd", 32'(req_cmd), 32'd0);
      chk("data_req_data", req_data, d2);
      if (stray_in_data) begin
        out_resp = 2'd1; out_data = $urandom; exp_stray = 1'b1;
      end
      step();
      out_resp = 2'd0;
      chk("wait_req_cmd", 32'(req_cmd), 32'd0);
      chk("wait_req_data", req_data, 32'd0);
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wait_stray", 32'(err_stray), 32'(exp_stray));
      edges = (n <= T) ? n : T;
      for (int i = 1; i <= edges; i++) begin
        if (i == n) begin
          out_resp = code; out_data = data;
        end
        step();
        out_resp = 2'd0; out_data = $urandom;
        if (i < edges) chk("wait_no_valid", 32'(rsp_valid), 32'd0);
      end
      if (n <= T) begin er = code; ed = data; et = 1'b0; end
      else begin er = 2'd0; ed = 32'd0; et = 1'b1; end
    end
    for (int s = 0; s <= stall; s++) begin
      chk("done_valid", 32'(rsp_valid), 32'd1);
      chk("done_resp", 32'(rsp_resp), 32'(er));
      chk("done_data", rsp_data, ed);
      chk("done_timeout", 32'(rsp_timeout), 32'(et));
      chk("done_op_ready", 32'(op_ready), 32'd0);
      chk("done_req_cmd", 32'(req_cmd), 32'd0);
      chk("done_stray", 32'(err_stray), 32'(exp_stray));
      if (s < stall) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hs_op_ready", 32'(op_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] cmds [7];
    cmds = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};
    reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_d1 = '0; op_d2 = '0;
    out_resp = '0; out_data = '0; rsp_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals("reset");
    #10 reset = 1'b1;
    step();
    check_reset_vals("post_reset");

    // ADD 5+7 answered on the first WAIT edge
    do_op(4'd1, 32'd5, 32'd7, 1, 2'd1, 32'd12, 0, 1'b0);
    // SUB answered invalid, host stalls 5 cycles
    do_op(4'd2, 32'd1, 32'd0, 2, 2'd2, 32'd0, 5, 1'b0);
    // LSH with no response ends by timeout
    do_op(4'd5, 32'hA5A5_0001, 32'd3, 99, 2'd1, 32'd0, 1, 1'b0);
    // NOP completes with no bus activity
    do_op(4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1, 2'd1, 32'd0, 0, 1'b0);
    // Stray response during DATA, operation still completes
    do_op(4'd1, 32'd10, 32'd20, 2, 2'd1, 32'd30, 0, 1'b1);
    // Response on the last possible WAIT edge
    do_op(4'd6, 32'h8000_0000, 32'd4, T, 2'd3, 32'hCAFE_F00D, 0, 1'b0);

    // Reset in WAIT abandons the op; a late response then flags stray
    op_valid = 1'b1; op_cmd = 4'd1; op_d1 = 32'hFFFF_FFFF; op_d2 = 32'd1;
    step();
    op_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1 exp_stray = 1'b0;
    check_reset_vals("mid_reset");
    #2 reset = 1'b1;
    out_resp = 2'd1; out_data = 32'd0;
    step();
    out_resp = 2'd0;
    exp_stray = 1'b1;
    chk("late_stray", 32'(err_stray), 32'd1);
    chk("late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_op_ready", 32'(op_ready), 32'd1);
    do_op(4'd2, 32'd3, 32'd10, 1, 2'd1, 32'd7, 0, 1'b0);

    // Randomized operations against the outcome model
    for (int k = 0; k < 25; k++) begin
      do_op(cmds[$urandom_range(0, 6)], $urandom, $urandom, $urandom_range(1, T + 2),
            2'($urandom_range(1, 3)), $urandom, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 Parameter: TIMEOUT, default 64, range 1..255; the number of WAIT cycles before an operation is abandoned.
REQ-002 Port: c_clk  input  1  the only clock; all state updates on posedge c_clk.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: op_valid  input  1  host offers an operation.
REQ-005 Port: op_ready  output  1  driver can accept an operation.
REQ-006 Port: op_cmd  input  [0:3]  command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; other codes pass through unchanged.
REQ-007 Port: op_d1, op_d2  input  [0:31] each  first and second operand.
REQ-008 Port: req_cmd  output  [0:3]  command to the calculator port.
REQ-009 Port: req_data  output  [0:31]  operand to the calculator port.
REQ-010 Port: out_resp  input  [0:1]  calculator response: 0 none, 1 success, 2 invalid/overflow, 3 internal error.
REQ-011 Port: out_data  input  [0:31]  calculator result.
REQ-012 Port: rsp_valid  output  1  a completed result is available to the host.
REQ-013 Port: rsp_ready  input  1  host accepts the result.
REQ-014 Port: rsp_resp  output  [0:1]  captured response code.
REQ-015 Port: rsp_data  output  [0:31]  captured result.
REQ-016 Port: rsp_timeout  output  1  the result was produced by timeout.
REQ-017 Port: err_stray  output  1  sticky flag: a response arrived while none was expected.

Function
REQ-018 The FSM SHALL have states IDLE, CMD, DATA, WAIT and DONE; op_ready SHALL be 1 only in IDLE.
REQ-019 An operation SHALL be accepted on a posedge with op_valid=1 in IDLE; op_cmd, op_d1 and op_d2 are latched on that edge.
- non-zero op_cmd: go to CMD.
- op_cmd=0: go straight to DONE with rsp_resp=0, rsp_data=0, rsp_timeout=0; nothing is driven on the bus.
REQ-020 In CMD (exactly one cycle): req_cmd=latched cmd, req_data=op_d1; then go to DATA.
REQ-021 In DATA (exactly one cycle): req_cmd=0, req_data=op_d2; then go to WAIT with the timeout counter cleared to 0.
REQ-022 In IDLE, WAIT and DONE: req_cmd=0 and req_data=0.
REQ-023 In WAIT, each posedge with out_resp!=0 SHALL capture rsp_resp=out_resp and rsp_data=out_data, clear rsp_timeout, and go to DONE.
REQ-024 In WAIT, each posedge with out_resp=0 SHALL increment the 8-bit counter.
- If the counter equals TIMEOUT-1 on that edge: go to DONE with rsp_resp=0, rsp_data=0, rsp_timeout=1.
REQ-025 rsp_valid SHALL be 1 exactly while in DONE; rsp_resp, rsp_data and rsp_timeout SHALL stay stable until the handshake.
REQ-026 A posedge in DONE with rsp_ready=1 SHALL return the FSM to IDLE; op_ready is 1 in the following cycle.
- Minimum issue-to-issue spacing: acceptance, CMD, DATA, >=1 WAIT, DONE.
REQ-027 A posedge where out_resp!=0 in any state other than WAIT SHALL set err_stray; the response is not captured and the FSM is unaffected.
- err_stray SHALL clear only on reset.
REQ-028 Latency: acceptance at edge k gives CMD in cycle k+1 and DATA in cycle k+2.
- A response sampled at edge k+2+n (n>=1) gives rsp_valid=1 from edge k+2+n onward.
REQ-029 Operand and result values SHALL pass through bit-exact; the driver performs no arithmetic on data.

Reset
REQ-030 While reset=0, asynchronously:
- FSM=IDLE, counter=0, op_ready=1, req_cmd=0, req_data=0.
- rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_timeout=0, err_stray=0.
REQ-031 Reset asserted mid-operation (CMD, DATA, WAIT or DONE) SHALL abandon the operation with no result reported.
- A late calculator response arriving after reset release with the FSM in IDLE SHALL set err_stray.

Verification
REQ-032 ADD, op_d1=5, op_d2=7:
- req_cmd/req_data = 1/5, then 0/7, then 0/0.
- out_resp=1, out_data=12 -> rsp_valid=1, rsp_resp=1, rsp_data=12, rsp_timeout=0.
REQ-033 SUB, op_d1=1, op_d2=0, calculator returns out_resp=2, out_data=0 -> rsp_resp=2, rsp_data=0; a stall on rsp_ready=0 for 5 cycles holds all rsp_* unchanged and op_ready=0.
REQ-034 TIMEOUT=4, LSH issued, out_resp held 0 -> DONE after exactly 4 WAIT edges with rsp_resp=0, rsp_timeout=1.
REQ-035 op_cmd=0 accepted -> no bus activity (req_cmd stays 0); rsp_valid=1 the next cycle with rsp_resp=0, rsp_timeout=0.
REQ-036 out_resp=1 injected during DATA -> err_stray=1 and remains 1.
- The operation still completes normally on a later WAIT response.
- err_stray clears only after reset=0.
REQ-037 reset=0 asserted in WAIT after ADD 0xFFFFFFFF+1, then released:
- all outputs at reset values; op_ready=1.
- a following SUB op_d1=3, op_d2=10 with out_resp=1, out_data=7 -> rsp_data=7.
